// File: rtl/wb_sdram_arbiter_if.sv
// Wishbone bundle between NUM_M system masters, the round-robin arbiter and the SDRAM slave port.
// Modport "slave" is the arbiter's view; "master" is the view of the masters plus the SDRAM top.
interface wb_sdram_arbiter_if #(
    parameter int NUM_M  = 4,
    parameter int APP_AW = 26,
    parameter int dw     = 32
);
    logic [NUM_M-1:0]          m_cyc_i;
    logic [NUM_M-1:0]          m_stb_i;
    logic [NUM_M-1:0]          m_we_i;
    logic [NUM_M*APP_AW-1:0]   m_addr_i;
    logic [NUM_M*dw-1:0]       m_dat_i;
    logic [NUM_M*dw/8-1:0]     m_sel_i;
    logic [NUM_M*3-1:0]        m_cti_i;
    logic [NUM_M-1:0]          m_ack_o;
    logic [dw-1:0]             m_dat_o;
    logic                      s_cyc_o;
    logic                      s_stb_o;
    logic                      s_we_o;
    logic [APP_AW-1:0]         s_addr_o;
    logic [dw-1:0]             s_dat_o;
    logic [dw/8-1:0]           s_sel_o;
    logic [2:0]                s_cti_o;
    logic                      s_ack_i;
    logic [dw-1:0]             s_dat_i;
    logic [NUM_M-1:0]          gnt_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i, s_ack_i, s_dat_i,
        output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o, gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o, gnt_o
    );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share the SDRAM controller slave port, one tenure
// per wb_cyc, with a forced idle cycle between tenures so the SDRAM top sees distinct cycles.
//
//  state | meaning
//  IDLE  | no owner, slave outputs low; next requester after last owner is granted at the edge
//  GRANT | gnt_q owner drives the slave port until its cyc is seen low at an edge
module wb_sdram_arbiter #(
    parameter int NUM_M  = 4,
    parameter int APP_AW = 26,
    parameter int dw     = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_sdram_arbiter_if.slave bus
);
    localparam int IDXW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW   = dw / 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [NUM_M-1:0]  gnt_q, gnt_d;
    logic [IDXW-1:0]   last_q, last_d;

    logic [IDXW-1:0]   pick_idx;
    logic              pick_vld;
    logic              owner_cyc;

    logic              s_stb;
    logic              s_we;
    logic [APP_AW-1:0] s_addr;
    logic [dw-1:0]     s_dat;
    logic [SW-1:0]     s_sel;
    logic [2:0]        s_cti;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IDXW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Scan requesters starting just after the previous owner so every master gets a turn.
    always_comb begin
        int            cand_int;
        logic [IDXW-1:0] cand;
        pick_idx = '0;
        pick_vld = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand_int = int'(last_q) + k;
            if (cand_int >= NUM_M) begin
                cand_int = cand_int - NUM_M;
            end
            cand = IDXW'(cand_int);
            if (!pick_vld && bus.m_cyc_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign owner_cyc = |(gnt_q & bus.m_cyc_i);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    gnt_d   = NUM_M'(1) << pick_idx;
                    last_d  = pick_idx;
                end
            end
            GRANT: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // gnt_q is one-hot or zero, so a plain select loop is a clean AND-OR mux.
    always_comb begin
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_addr = '0;
        s_dat  = '0;
        s_sel  = '0;
        s_cti  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_q[i]) begin
                s_stb  = bus.m_stb_i[i];
                s_we   = bus.m_we_i[i];
                s_addr = bus.m_addr_i[i*APP_AW +: APP_AW];
                s_dat  = bus.m_dat_i[i*dw +: dw];
                s_sel  = bus.m_sel_i[i*SW +: SW];
                s_cti  = bus.m_cti_i[i*3 +: 3];
            end
        end
    end

    assign bus.s_cyc_o  = owner_cyc;
    assign bus.s_stb_o  = s_stb;
    assign bus.s_we_o   = s_we;
    assign bus.s_addr_o = s_addr;
    assign bus.s_dat_o  = s_dat;
    assign bus.s_sel_o  = s_sel;
    assign bus.s_cti_o  = s_cti;
    // An ack arriving with no owner is dropped because gnt_q is zero.
    assign bus.m_ack_o  = gnt_q & bus.m_cyc_i & {NUM_M{bus.s_ack_i}};
    assign bus.m_dat_o  = bus.s_dat_i;
    assign bus.gnt_o    = gnt_q;
endmodule
